debug_loader: RTL and testbench
===============================

Name: debug_loader

Overview:
- Write side of the instruction-memory debug load port; the fetch stage's instruction memory consumes this port.
- Receives a byte stream from the host link (UART receiver output) and parses a framed program image.
- Assembles 32-bit instruction words and drives DEBUG_SIG / DEBUG_addr / DEBUG_instr with a write strobe, one word per write.
- Holds DEBUG_SIG high for the whole load so the core stays out of normal fetch.

Parameters:
- BASE_ADDR, 32'h0, word address of the first instruction written (the PC counts in words).
- TIMEOUT_CYCLES, 100000, maximum idle cycles between bytes inside a frame before the frame is aborted.
- MAGIC, 8'hA5, frame start byte.

Ports:
- clk  in  1  core clock.
- nrst  in  1  asynchronous active-low reset.
- rx_valid  in  1  one-cycle strobe, rx_byte valid; at most one byte per cycle.
- rx_byte  in  8  received byte.
- DEBUG_SIG  out  1  high while a frame is being loaded.
- DEBUG_addr  out  32  word address of the current write.
- DEBUG_instr  out  32  instruction word of the current write.
- DEBUG_we  out  1  one-cycle write strobe; addr and instr are valid when it is high.
- load_done  out  1  one-cycle pulse when a frame completes cleanly.
- load_err  out  1  sticky error; cleared when the next MAGIC byte is accepted.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: every output is 0, state is IDLE, all counters are 0.
- Frame format: MAGIC, CNT_LO, CNT_HI (N = 16-bit word count), then N×4 data bytes, each word little-endian.
- FSM states: IDLE, CNT_LO, CNT_HI, DATA, DONE.
- IDLE: any byte other than MAGIC is ignored. MAGIC moves to CNT_LO, clears load_err and sets DEBUG_SIG.
- CNT_LO → CNT_HI on the next byte. CNT_HI → DATA when N ≠ 0; CNT_HI → DONE when N = 0.
- DATA: a byte lane counter (0..3) shifts bytes into the word.
- On the 4th byte, the next cycle has DEBUG_we=1, DEBUG_instr = the assembled word, DEBUG_addr = BASE_ADDR + word index. Latency is 1 cycle.
- The word index then increments. After word N-1 is written, the FSM goes to DONE.
- DONE lasts one cycle: load_done=1, then DEBUG_SIG=0 and return to IDLE.
- Address arithmetic is 32-bit modulo 2^32; wrap-around is silent.
- DEBUG_addr and DEBUG_instr hold their last values when DEBUG_we=0.
- Timeout counter: cleared on every accepted byte; counts only when the state is not IDLE.
  - Reaching TIMEOUT_CYCLES sets load_err and drops DEBUG_SIG.
  - The partial word is discarded; words already written stay written; the FSM returns to IDLE with no load_done.
- MAGIC bytes inside a frame are data, not a restart.
- rx_valid on the same cycle as a write strobe is accepted normally; back-to-back bytes are legal in every state.
- Reset mid-frame aborts immediately: outputs go to reset values and no further writes occur.

Optional Feature:
- Macro: DEBUG_LOADER_CHECKSUM_EN.
- Defined: an extra CHK state follows the last data word, or follows CNT_HI when N = 0.
  - It expects one byte equal to the XOR of all data bytes.
  - Match → DONE. Mismatch → load_err=1, no load_done, return to IDLE.
  - Timeout applies in CHK as in other frame states.
- Undefined: no CHK state and no checksum logic; the frame ends after the last data word.

Decomposition:
- Shared package: FSM state enum and MAGIC default constant.
- Also in the package: word and address width constants, shared with the instruction memory.
- One natural sub-module: debug_word_assembler (lane counter, byte shift register, word-ready pulse).
- The FSM, address counter and timeout counter stay in debug_loader.

Test Plan:
- Send A5 02 00 13 00 00 00 93 00 10 00 → DEBUG_we pulses twice:
  - addr 0 with instr 0x00000013;
  - addr 1 with instr 0x00100093.
  - Then load_done for 1 cycle and DEBUG_SIG falls.
- Send bytes 00 FF before A5 → ignored; busy stays 0 until A5.
- Send A5 00 00 → no DEBUG_we, load_done pulses; with CHECKSUM_EN, an added byte 00 is needed first.
- Send A5 01 00 11 22, then idle for TIMEOUT_CYCLES → load_err=1, DEBUG_SIG=0, no DEBUG_we. The next A5 clears load_err.
- Assert nrst low in the middle of the 3rd data byte → all outputs 0 immediately. A following full frame loads correctly from BASE_ADDR.
- CHECKSUM_EN, one word 01 02 03 04 with checksum 04 → load_done. Checksum 05 → load_err, no load_done.

Source files
------------

// File: rtl/debug_loader_pkg.sv
// Shared types and constants for the instruction-memory debug loader.
// Optional macro DEBUG_LOADER_CHECKSUM_EN adds the checksum state to the FSM enum.
package debug_loader_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned CNT_W  = 16;

    localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CNT_LO = 3'd1,
        ST_CNT_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_DONE   = 3'd4
`ifdef DEBUG_LOADER_CHECKSUM_EN
        ,
        ST_CHK    = 3'd5
`endif
    } state_t;

    // Word address of a write; wraps modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [CNT_W-1:0]  idx);
        return base + {{(ADDR_W-CNT_W){1'b0}}, idx};
    endfunction

endpackage

// File: rtl/debug_word_assembler.sv
// Collects four little-endian bytes into one instruction word.
// word/word_ready are valid combinationally in the cycle the fourth byte is presented.
module debug_word_assembler
    import debug_loader_pkg::*;
(
    input  logic              clk,
    input  logic              nrst,
    input  logic              clear,
    input  logic              byte_valid,
    input  logic [7:0]        byte_in,
    output logic [WORD_W-1:0] word,
    output logic              word_ready
);

    logic [1:0]        lane_r;
    logic [WORD_W-9:0] shift_r;

    assign word       = {byte_in, shift_r};
    assign word_ready = byte_valid && (lane_r == 2'd3);

    // Lane counter and shift register; clear drops any partial word.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            lane_r  <= 2'd0;
            shift_r <= {(WORD_W-8){1'b0}};
        end else if (clear) begin
            lane_r  <= 2'd0;
            shift_r <= {(WORD_W-8){1'b0}};
        end else if (byte_valid) begin
            lane_r  <= lane_r + 2'd1;
            shift_r <= {byte_in, shift_r[WORD_W-9:8]};
        end
    end

endmodule

// File: rtl/debug_loader.sv
// Parses framed program images from the host byte stream and writes them into instruction memory.
// Optional macro DEBUG_LOADER_CHECKSUM_EN appends an XOR checksum byte to every frame.
module debug_loader
    import debug_loader_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR      = 32'h0,
    parameter int unsigned       TIMEOUT_CYCLES = 100000,
    parameter logic [7:0]        MAGIC          = MAGIC_DEFAULT
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    output logic              DEBUG_SIG,
    output logic [ADDR_W-1:0] DEBUG_addr,
    output logic [WORD_W-1:0] DEBUG_instr,
    output logic              DEBUG_we,
    output logic              load_done,
    output logic              load_err,
    output logic              busy
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

`ifdef DEBUG_LOADER_CHECKSUM_EN
    localparam state_t ST_TAIL = ST_CHK;
`else
    localparam state_t ST_TAIL = ST_DONE;
`endif

    state_t            state_r;
    state_t            state_nx;
    logic [TMO_W-1:0]  tmo_r;
    logic [7:0]        cnt_lo_r;
    logic [CNT_W-1:0]  count_r;
    logic [CNT_W-1:0]  word_idx_r;
    logic              busy_r;
    logic              we_r;
    logic              done_r;
    logic              err_r;
    logic [ADDR_W-1:0] addr_r;
    logic [WORD_W-1:0] instr_r;
`ifdef DEBUG_LOADER_CHECKSUM_EN
    logic [7:0]        csum_r;
`endif

    logic              timeout_s;
    logic              magic_s;
    logic              last_word_s;
    logic [CNT_W-1:0]  count_s;
    logic              data_byte_s;
    logic              word_ready_s;
    logic [WORD_W-1:0] word_s;
    logic              start_s;
    logic              err_set_s;

    assign timeout_s   = (state_r != ST_IDLE) && (tmo_r == TMO_W'(TIMEOUT_CYCLES));
    assign magic_s     = rx_valid && (rx_byte == MAGIC);
    assign count_s     = {rx_byte, cnt_lo_r};
    assign last_word_s = (word_idx_r == (count_r - 16'd1));
    assign data_byte_s = rx_valid && (state_r == ST_DATA) && !timeout_s;

    debug_word_assembler u_asm (
        .clk        (clk),
        .nrst       (nrst),
        .clear      (state_r != ST_DATA),
        .byte_valid (data_byte_s),
        .byte_in    (rx_byte),
        .word       (word_s),
        .word_ready (word_ready_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Next-state logic; a timeout overrides whatever byte arrives that cycle.
    always_comb begin
        state_nx  = state_r;
        start_s   = 1'b0;
        err_set_s = 1'b0;
        if (timeout_s) begin
            state_nx  = ST_IDLE;
            err_set_s = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (magic_s) begin
                        state_nx = ST_CNT_LO;
                        start_s  = 1'b1;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end
                ST_CNT_LO: begin
                    if (rx_valid) begin
                        state_nx = ST_CNT_HI;
                    end else begin
                        state_nx = ST_CNT_LO;
                    end
                end
                ST_CNT_HI: begin
                    if (!rx_valid) begin
                        state_nx = ST_CNT_HI;
                    end else if (count_s != 16'd0) begin
                        state_nx = ST_DATA;
                    end else begin
                        state_nx = ST_TAIL;
                    end
                end
                ST_DATA: begin
                    if (word_ready_s && last_word_s) begin
                        state_nx = ST_TAIL;
                    end else begin
                        state_nx = ST_DATA;
                    end
                end
`ifdef DEBUG_LOADER_CHECKSUM_EN
                ST_CHK: begin
                    if (!rx_valid) begin
                        state_nx = ST_CHK;
                    end else if (rx_byte == csum_r) begin
                        state_nx = ST_DONE;
                    end else begin
                        state_nx  = ST_IDLE;
                        err_set_s = 1'b1;
                    end
                end
`endif
                // A MAGIC arriving back-to-back with the end of a frame starts the next one.
                ST_DONE: begin
                    if (magic_s) begin
                        state_nx = ST_CNT_LO;
                        start_s  = 1'b1;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end
                default: begin
                    state_nx = ST_IDLE;
                end
            endcase
        end
    end

    // Frame bookkeeping: word count, word index, idle timeout and running checksum.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            tmo_r      <= TMO_W'(0);
            cnt_lo_r   <= 8'h00;
            count_r    <= 16'd0;
            word_idx_r <= 16'd0;
`ifdef DEBUG_LOADER_CHECKSUM_EN
            csum_r     <= 8'h00;
`endif
        end else begin
            if ((state_r == ST_IDLE) || rx_valid || timeout_s) begin
                tmo_r <= TMO_W'(0);
            end else begin
                tmo_r <= tmo_r + TMO_W'(1);
            end
            if ((state_r == ST_CNT_LO) && rx_valid) begin
                cnt_lo_r <= rx_byte;
            end
            if ((state_r == ST_CNT_HI) && rx_valid) begin
                count_r <= count_s;
            end
            if (start_s) begin
                word_idx_r <= 16'd0;
            end else if (word_ready_s) begin
                word_idx_r <= word_idx_r + 16'd1;
            end
`ifdef DEBUG_LOADER_CHECKSUM_EN
            if (start_s) begin
                csum_r <= 8'h00;
            end else if (data_byte_s) begin
                csum_r <= csum_r ^ rx_byte;
            end
`endif
        end
    end

    // Registered outputs; the write appears the cycle after the fourth byte.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            busy_r  <= 1'b0;
            we_r    <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            addr_r  <= {ADDR_W{1'b0}};
            instr_r <= {WORD_W{1'b0}};
        end else begin
            busy_r <= (state_nx != ST_IDLE);
            we_r   <= word_ready_s;
            done_r <= (state_nx == ST_DONE);
            if (start_s) begin
                err_r <= 1'b0;
            end else if (err_set_s) begin
                err_r <= 1'b1;
            end
            if (word_ready_s) begin
                addr_r  <= word_addr(BASE_ADDR, word_idx_r);
                instr_r <= word_s;
            end
        end
    end

    // DEBUG_SIG and busy both mean "not idle", so they share one flop.
    assign DEBUG_SIG   = busy_r;
    assign busy        = busy_r;
    assign DEBUG_we    = we_r;
    assign DEBUG_addr  = addr_r;
    assign DEBUG_instr = instr_r;
    assign load_done   = done_r;
    assign load_err    = err_r;

endmodule

// File: tb/tb_debug_loader.sv
// Scoreboard bench for debug_loader: expected writes are queued as frames are sent.
// Build with DEBUG_LOADER_CHECKSUM_EN to exercise the checksum byte.
module tb_debug_loader;

    localparam int          T    = 40;
    localparam logic [31:0] BASE = 32'h0;

    logic        clk;
    logic        nrst;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        DEBUG_SIG;
    logic [31:0] DEBUG_addr;
    logic [31:0] DEBUG_instr;
    logic        DEBUG_we;
    logic        load_done;
    logic        load_err;
    logic        busy;

    int          checks;
    int          errors;
    int          done_cnt;
    int          we_cnt;
    int          push_cnt;
    int          done0;
    logic [63:0] sb[$];
    logic [63:0] exp_e;
    logic [31:0] frame_w[0:3];

    debug_loader #(
        .BASE_ADDR      (BASE),
        .TIMEOUT_CYCLES (T),
        .MAGIC          (8'hA5)
    ) dut (
        .clk         (clk),
        .nrst        (nrst),
        .rx_valid    (rx_valid),
        .rx_byte     (rx_byte),
        .DEBUG_SIG   (DEBUG_SIG),
        .DEBUG_addr  (DEBUG_addr),
        .DEBUG_instr (DEBUG_instr),
        .DEBUG_we    (DEBUG_we),
        .load_done   (load_done),
        .load_err    (load_err),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_byte  = b;
    endtask

    task automatic idle();
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic expect_write(input logic [31:0] idx, input logic [31:0] w);
        sb.push_back({BASE + idx, w});
        push_cnt++;
    endtask

    // Sends MAGIC, count, frame_w[0..n-1] and (if enabled) a correct checksum.
    task automatic send_frame(input int n);
        logic [31:0] w;
`ifdef DEBUG_LOADER_CHECKSUM_EN
        logic [7:0]  cs;
        cs = 8'h00;
`endif
        send_byte(8'hA5);
        send_byte(n[7:0]);
        send_byte(n[15:8]);
        for (int i = 0; i < n; i++) begin
            w = frame_w[i];
            expect_write(i, w);
            for (int b = 0; b < 4; b++) begin
                send_byte(w[8*b +: 8]);
`ifdef DEBUG_LOADER_CHECKSUM_EN
                cs = cs ^ w[8*b +: 8];
`endif
            end
        end
`ifdef DEBUG_LOADER_CHECKSUM_EN
        send_byte(cs);
`endif
        idle();
    endtask

    // Monitor: every write strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (nrst && DEBUG_we) begin
            we_cnt++;
            if (sb.size() == 0) begin
                chk("we_unexpected", 64'(DEBUG_addr), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                exp_e = sb.pop_front();
                chk("we_addr", 64'(DEBUG_addr), 64'(exp_e[63:32]));
                chk("we_instr", 64'(DEBUG_instr), 64'(exp_e[31:0]));
            end
        end
        if (nrst && load_done) begin
            done_cnt++;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        checks   = 0;
        errors   = 0;
        done_cnt = 0;
        we_cnt   = 0;
        push_cnt = 0;
        nrst     = 1'b0;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_data", {DEBUG_addr, DEBUG_instr}, 64'h0);
        chk("rst_flags", 64'({DEBUG_SIG, DEBUG_we, load_done, load_err, busy}), 64'h0);
        nrst = 1'b1;
        idle();

        // Two-word frame with explicit latency and end-of-frame timing checks.
        expect_write(0, 32'h0000_0013);
        expect_write(1, 32'h0010_0093);
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
        idle();
        chk("sig_in_frame", 64'(DEBUG_SIG), 64'h1);
        chk("busy_in_frame", 64'(busy), 64'h1);
        send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        idle();
        chk("we_latency", 64'(DEBUG_we), 64'h1);
        send_byte(8'h93); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
`ifdef DEBUG_LOADER_CHECKSUM_EN
        send_byte(8'h90);
`endif
        idle();
        chk("done_pulse", 64'(load_done), 64'h1);
        idle();
        chk("done_width", 64'(load_done), 64'h0);
        chk("sig_fall", 64'(DEBUG_SIG), 64'h0);
        chk("done_once", 64'(done_cnt), 64'd1);

        // Garbage before MAGIC is ignored.
        send_byte(8'h00); send_byte(8'hFF);
        idle();
        chk("garbage_busy", 64'(busy), 64'h0);
        chk("garbage_sig", 64'(DEBUG_SIG), 64'h0);

        // Zero-length frame: done without any write.
        done0 = done_cnt;
        send_frame(0);
        repeat (3) idle();
        chk("empty_done", 64'(done_cnt), 64'(done0 + 1));
        chk("empty_nowrite", 64'(we_cnt), 64'(push_cnt));

        // Timeout with a partial word pending.
        done0 = done_cnt;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22);
        repeat (T - 1) idle();
        chk("tmo_early_err", 64'(load_err), 64'h0);
        chk("tmo_early_sig", 64'(DEBUG_SIG), 64'h1);
        repeat (3) idle();
        chk("tmo_err", 64'(load_err), 64'h1);
        chk("tmo_sig", 64'(DEBUG_SIG), 64'h0);
        chk("tmo_busy", 64'(busy), 64'h0);
        chk("tmo_nodone", 64'(done_cnt), 64'(done0));
        send_byte(8'hA5);
        idle();
        chk("err_cleared", 64'(load_err), 64'h0);
        expect_write(0, 32'hDDCC_BBAA);
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
`ifdef DEBUG_LOADER_CHECKSUM_EN
        send_byte(8'h00);
`endif
        repeat (3) idle();
        chk("resume_done", 64'(done_cnt), 64'(done0 + 1));

        // MAGIC bytes inside the data are plain data.
        done0 = done_cnt;
        frame_w[0] = 32'hA5A5_A5A5;
        frame_w[1] = 32'hDEAD_BEEF;
        send_frame(2);
        repeat (3) idle();
        chk("magic_data_done", 64'(done_cnt), 64'(done0 + 1));

        // Reset in the middle of the third data byte.
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'h02);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_byte  = 8'h03;
        #2;
        nrst = 1'b0;
        #1;
        chk("midrst_data", {DEBUG_addr, DEBUG_instr}, 64'h0);
        chk("midrst_flags", 64'({DEBUG_SIG, DEBUG_we, load_done, load_err, busy}), 64'h0);
        @(negedge clk);
        rx_valid = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        done0 = done_cnt;
        frame_w[0] = 32'h1234_5678;
        send_frame(1);
        repeat (3) idle();
        chk("after_rst_done", 64'(done_cnt), 64'(done0 + 1));

`ifdef DEBUG_LOADER_CHECKSUM_EN
        // Good then bad checksum.
        done0 = done_cnt;
        frame_w[0] = 32'h0403_0201;
        send_frame(1);
        repeat (3) idle();
        chk("chk_good_done", 64'(done_cnt), 64'(done0 + 1));
        chk("chk_good_err", 64'(load_err), 64'h0);
        done0 = done_cnt;
        expect_write(0, 32'h0403_0201);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        send_byte(8'h05);
        repeat (3) idle();
        chk("chk_bad_err", 64'(load_err), 64'h1);
        chk("chk_bad_nodone", 64'(done_cnt), 64'(done0));
        chk("chk_bad_sig", 64'(DEBUG_SIG), 64'h0);
`endif

        repeat (3) idle();
        chk("sb_drain", 64'(sb.size()), 64'h0);
        chk("we_total", 64'(we_cnt), 64'(push_cnt));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
